// File: rtl/cache_replacement_unit.sv
// Tree pseudo-LRU replacement unit: one heap-ordered PLRU tree per cache set,
// giving a zero-latency victim for the addressed set and updating recency on
// every access and every replacement.
module cache_replacement_unit #(
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [$clog2(NUM_SETS)-1:0] set,
  input  logic                        access_valid,
  input  logic [$clog2(NUM_WAYS)-1:0] access_way,
  input  logic                        cru_enable,
  output logic [$clog2(NUM_WAYS)-1:0] replace_way
);

  localparam int SetSize = $clog2(NUM_SETS);
  localparam int WaySize = $clog2(NUM_WAYS);

  // Handshake: cru_enable and access_valid are single-cycle strobes with no
  // ready/backpressure; each is consumed at the rising edge it is sampled on,
  // and cru_enable takes precedence when both are high.

  // Tree bit n of a set: 0 = LRU side is the left subtree, 1 = right subtree.
  logic [NUM_WAYS-2:0] plru_q [NUM_SETS];

  logic [NUM_WAYS-2:0] cur_tree;
  logic [WaySize-1:0]  victim;
  logic [WaySize-1:0]  node;

  // The node visited at level l is (2^l - 1) plus the path prefix taken so far,
  // which is exactly the heap child rule 2i+1 / 2i+2 unrolled.
  function automatic logic [NUM_WAYS-2:0] touch(input logic [NUM_WAYS-2:0] tree,
                                                input logic [WaySize-1:0]  way);
    logic [WaySize-1:0] n;
    touch = tree;
    for (int l = 0; l < WaySize; l++) begin
      n = WaySize'((1 << l) - 1 + int'(way >> (WaySize - l)));
      touch[n] = ~way[WaySize-1-l];
    end
  endfunction

  always_comb begin
    cur_tree = plru_q[set];
    victim   = '0;
    node     = '0;
    for (int l = 0; l < WaySize; l++) begin
      node = WaySize'((1 << l) - 1 + int'(victim >> (WaySize - l)));
      victim[WaySize-1-l] = cur_tree[node];
    end
  end

  assign replace_way = victim;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        plru_q[s] <= '0;
      end
    end else if (cru_enable) begin
      plru_q[set] <= touch(plru_q[set], victim);
    end else if (access_valid) begin
      plru_q[set] <= touch(plru_q[set], access_way);
    end
  end

  logic unused_set_size;
  assign unused_set_size = (SetSize == 0);

endmodule

// File: tb/tb_cache_replacement_unit.sv
// Bench for cache_replacement_unit: directed scenarios then random traffic,
// each cycle checked against a per-set heap-tree reference model.
module tb_cache_replacement_unit;

  localparam int NUM_SETS = 16;
  localparam int NUM_WAYS = 4;
  localparam int SET_W    = 4;
  localparam int WAY_W    = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [SET_W-1:0] set = '0;
  logic             access_valid = 1'b0;
  logic [WAY_W-1:0] access_way = '0;
  logic             cru_enable = 1'b0;
  logic [WAY_W-1:0] replace_way;

  int vectors     = 0;
  int miscompares = 0;

  bit model [NUM_SETS][NUM_WAYS-1];

  // clock / reset block
  always #5 clk = ~clk;

  cache_replacement_unit #(
    .NUM_SETS(NUM_SETS),
    .NUM_WAYS(NUM_WAYS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .set         (set),
    .access_valid(access_valid),
    .access_way  (access_way),
    .cru_enable  (cru_enable),
    .replace_way (replace_way)
  );

  // reference model: explicit heap walk, node i -> children 2i+1 / 2i+2
  function automatic int model_victim(input int s);
    int node = 0;
    int v = 0;
    for (int l = 0; l < WAY_W; l++) begin
      int b = int'(model[s][node]);
      v = v * 2 + b;
      node = 2 * node + 1 + b;
    end
    return v;
  endfunction

  task automatic model_touch(input int s, input int w);
    int node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      int d = (w >> (WAY_W - 1 - l)) & 1;
      model[s][node] = (d == 0);
      node = 2 * node + 1 + d;
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NUM_SETS; s++)
      for (int n = 0; n < NUM_WAYS - 1; n++)
        model[s][n] = 1'b0;
  endtask

  task automatic check(input string tag, input logic [WAY_W-1:0] obs, input logic [WAY_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver: one clocked step, victim checked before the edge, model updated at it
  task automatic cycle(input int s, input logic av, input int aw, input logic ce, input logic r);
    int v;
    @(negedge clk);
    set = SET_W'(s);
    access_valid = av;
    access_way = WAY_W'(aw);
    cru_enable = ce;
    rst = r;
    #1;
    v = model_victim(s);
    check("victim_vs_model", replace_way, WAY_W'(v));
    @(posedge clk);
    if (r) model_reset();
    else if (ce) model_touch(s, v);
    else if (av) model_touch(s, aw % NUM_WAYS);
  endtask

  // idle observation of one set against a directed expectation and the model
  task automatic peek(input string tag, input int s, input int exp);
    @(negedge clk);
    set = SET_W'(s);
    access_valid = 1'b0;
    cru_enable = 1'b0;
    rst = 1'b0;
    #1;
    check(tag, replace_way, WAY_W'(exp));
    check("peek_vs_model", replace_way, WAY_W'(model_victim(s)));
  endtask

  initial begin
    int exp_acc [4] = '{2, 1, 3, 0};
    int acc_seq [4] = '{0, 2, 1, 3};
    int exp_cru [5] = '{0, 2, 1, 3, 0};

    model_reset();
    @(posedge clk);
    cycle(0, 1'b0, 0, 1'b0, 1'b1);

    peek("reset_set3", 3, 0);
    peek("reset_set0", 0, 0);
    peek("reset_set15", 15, 0);

    for (int i = 0; i < 4; i++) begin
      cycle(3, 1'b1, acc_seq[i], 1'b0, 1'b0);
      peek("access_seq_set3", 3, exp_acc[i]);
    end

    for (int i = 0; i < 5; i++) begin
      peek("cru_round_robin", 3, exp_cru[i]);
      cycle(3, 1'b0, 0, 1'b1, 1'b0);
    end

    cycle(5, 1'b1, 0, 1'b0, 1'b0);
    peek("isolation_set6", 6, 0);
    peek("isolation_set5", 5, 2);

    cycle(7, 1'b1, 3, 1'b1, 1'b0);
    peek("cru_wins_set7", 7, 2);

    cycle(9, 1'b1, 1, 1'b0, 1'b0);
    peek("pre_reset_set9", 9, 2);
    cycle(3, 1'b0, 0, 1'b1, 1'b1);
    for (int s = 0; s < NUM_SETS; s++) peek("mid_reset_all", s, 0);

    for (int i = 0; i < 400; i++) begin
      cycle(int'($urandom_range(NUM_SETS - 1, 0)),
            logic'($urandom_range(1, 0)),
            int'($urandom_range(NUM_WAYS - 1, 0)),
            ($urandom_range(3, 0) == 0),
            ($urandom_range(99, 0) == 0));
    end
    for (int s = 0; s < NUM_SETS; s++) peek("final_sweep", s, model_victim(s));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
